// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths.
//   - baud code values carried on the 2-bit baud_rate bus
//   - nominal bit periods in system_clk cycles (200 MHz clock)
//   - bit_cycles(): maps a baud code to its bit period
//   - transmit FSM state encoding
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] BAUD_9600  = 2'b00;
    localparam logic [1:0] BAUD_19200 = 2'b01;
    localparam logic [1:0] BAUD_38400 = 2'b10;
    localparam logic [1:0] BAUD_57600 = 2'b11;

    typedef logic [15:0] bit_cyc_t;

    localparam bit_cyc_t BIT_CYC_9600  = 16'd20833;
    localparam bit_cyc_t BIT_CYC_19200 = 16'd10416;
    localparam bit_cyc_t BIT_CYC_38400 = 16'd5208;
    localparam bit_cyc_t BIT_CYC_57600 = 16'd3472;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic bit_cyc_t bit_cycles(input logic [1:0] baud_rate);
        bit_cyc_t cyc;
        case (baud_rate)
            BAUD_9600:  cyc = BIT_CYC_9600;
            BAUD_19200: cyc = BIT_CYC_19200;
            BAUD_38400: cyc = BIT_CYC_38400;
            BAUD_57600: cyc = BIT_CYC_57600;
            default:    cyc = BIT_CYC_9600;
        endcase
        return cyc;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_tx_baud_tick
// Restartable bit-period divider for the UART transmitter.
// Ports:
//   system_clk  in   system clock
//   reset_n     in   asynchronous active-low reset
//   restart     in   zeroes the count (frame acceptance)
//   divisor     in   cycles per bit
//   bit_end     out  high for the one cycle where count == divisor-1
// ----------------------------------------------------------------------------
module uart_tx_baud_tick
    import uart_pkg::*;
(
    input  logic     system_clk,
    input  logic     reset_n,
    input  logic     restart,
    input  bit_cyc_t divisor,
    output logic     bit_end
);

    bit_cyc_t count;

    // The count returns to zero on the terminal value, so each bit spans
    // exactly 'divisor' cycles and the counter never runs past it.
    assign bit_end = (count == bit_cyc_t'(divisor - 16'd1));

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (restart || bit_end) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// ----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmit path: takes bytes over a valid/ready handshake and sends
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
// bits on tx_serial. All outputs are registered.
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   PARITY_EN   1 = append parity bit
//   PARITY_ODD  1 = odd parity, 0 = even
//   STOP_BITS   1 or 2
//   CYC_SHIFT   right shift applied to the bit-period table; 0 = nominal rates
// Ports:
//   system_clk  in   system clock (200 MHz nominal)
//   reset_n     in   asynchronous active-low reset
//   baud_rate   in   2-bit baud code, sampled at acceptance
//   tx_data     in   byte to send, sampled at acceptance
//   tx_valid    in   byte offered
//   tx_ready    out  idle, can accept a byte
//   tx_serial   out  serial line, idles high
//   tx_busy     out  frame in progress
//   tx_done     out  one-cycle pulse when a frame completes
// ----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int CYC_SHIFT  = 0
) (
    input  logic                 system_clk,
    input  logic                 reset_n,
    input  logic [1:0]           baud_rate,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int IDX_W = $clog2(DATA_BITS);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 parity_bit;
    logic [1:0]           baud_q;
    bit_cyc_t             divisor;
    logic                 accept;
    logic                 bit_end;

    assign accept  = tx_valid && tx_ready;
    // Divisor follows the latched code only, so baud_rate may change freely
    // while a frame is on the line.
    assign divisor = bit_cycles(baud_q) >> CYC_SHIFT;

    uart_tx_baud_tick u_tick (
        .system_clk (system_clk),
        .reset_n    (reset_n),
        .restart    (accept),
        .divisor    (divisor),
        .bit_end    (bit_end)
    );

    always_ff @(posedge system_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
            baud_q     <= BAUD_9600;
            tx_serial  <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    if (accept) begin
                        // Start bit goes out in the cycle right after acceptance.
                        shreg      <= tx_data;
                        baud_q     <= baud_rate;
                        parity_bit <= (^tx_data) ^ 1'(PARITY_ODD);
                        bit_idx    <= '0;
                        stop_cnt   <= 1'b0;
                        tx_serial  <= 1'b0;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_serial <= shreg[0];
                        shreg     <= shreg >> 1;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                tx_serial <= parity_bit;
                                state     <= PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                state     <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            tx_serial <= shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            tx_serial <= 1'b1;
                            tx_ready  <= 1'b1;
                            tx_busy   <= 1'b0;
                            tx_done   <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    // DUT set: 0 = nominal 8N1, 1 = 8O2, 2 = 8E1, 3 = 8N1, 4 = 5N2 (1..4 with shortened bit periods)
    localparam int NDUT = 5;
    localparam int P_DB [NDUT] = '{8, 8, 8, 8, 5};
    localparam int P_PE [NDUT] = '{0, 1, 1, 0, 0};
    localparam int P_PO [NDUT] = '{0, 1, 0, 0, 0};
    localparam int P_SB [NDUT] = '{1, 2, 1, 1, 2};
    localparam int P_SH [NDUT] = '{0, 6, 6, 6, 6};
    localparam int NOMINAL [4] = '{20833, 10416, 5208, 3472};

    typedef struct {
        logic [1:0] baud;
        logic [7:0] data;
        logic [9:0] bits;    // bit k = level of frame bit k (start first)
        int         cycles;  // frame length in cycles for DUT 3
    } vec_t;

    logic       system_clk = 1'b0;
    logic       reset_n    = 1'b0;
    logic [1:0] baud_rate  = 2'b00;
    logic [7:0] tx_data    = 8'h00;
    logic       tx_valid   = 1'b0;

    logic ser [NDUT];
    logic rdy [NDUT];
    logic bsy [NDUT];
    logic dn  [NDUT];
    logic e_ser [NDUT];
    logic e_rdy [NDUT];
    logic e_bsy [NDUT];
    logic e_dn  [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 system_clk = ~system_clk;
    always @(posedge system_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gd
        localparam int DB = P_DB[g];
        localparam int PE = P_PE[g];
        localparam int PO = P_PO[g];
        localparam int SB = P_SB[g];
        localparam int SH = P_SH[g];
        localparam int F  = 1 + DB + PE + SB;

        uart_tx_serializer #(
            .DATA_BITS(DB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB), .CYC_SHIFT(SH)
        ) dut (
            .system_clk (system_clk),
            .reset_n    (reset_n),
            .baud_rate  (baud_rate),
            .tx_data    (tx_data[DB-1:0]),
            .tx_valid   (tx_valid),
            .tx_ready   (rdy[g]),
            .tx_serial  (ser[g]),
            .tx_busy    (bsy[g]),
            .tx_done    (dn[g])
        );

        // Reference: a frame is a list of line levels; the level at elapsed
        // cycle e since acceptance is levels[e / period].
        function automatic logic [11:0] frame_levels(input logic [7:0] d);
            logic [11:0] v;
            v = '1;
            v[0] = 1'b0;
            for (int i = 0; i < DB; i++) v[1+i] = d[i];
            if (PE != 0) v[1+DB] = (^(d & 8'((1 << DB) - 1))) ^ (PO != 0);
            return v;
        endfunction

        logic        m_act, m_ser, m_dn;
        logic [11:0] m_lv;
        int          m_el, m_per;

        always @(posedge system_clk or negedge reset_n) begin
            if (!reset_n) begin
                m_act <= 1'b0; m_ser <= 1'b1; m_dn <= 1'b0;
                m_el  <= 0;    m_per <= 1;    m_lv <= '1;
            end else begin
                m_dn <= 1'b0;
                if (!m_act) begin
                    m_ser <= 1'b1;
                    if (tx_valid) begin
                        m_lv  <= frame_levels(tx_data);
                        m_per <= NOMINAL[baud_rate] >> SH;
                        m_el  <= 0;
                        m_act <= 1'b1;
                        m_ser <= 1'b0;
                    end
                end else if (m_el + 1 == F * m_per) begin
                    m_act <= 1'b0;
                    m_dn  <= 1'b1;
                    m_ser <= 1'b1;
                end else begin
                    m_el  <= m_el + 1;
                    m_ser <= m_lv[(m_el + 1) / m_per];
                end
            end
        end

        assign e_ser[g] = m_ser;
        assign e_rdy[g] = !m_act;
        assign e_bsy[g] = m_act;
        assign e_dn[g]  = m_dn;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every DUT with its model.
    task automatic tick();
        @(negedge system_clk);
        for (int g = 0; g < NDUT; g++) begin
            chk("serial", g, 32'(ser[g]), 32'(e_ser[g]));
            chk("ready",  g, 32'(rdy[g]), 32'(e_rdy[g]));
            chk("busy",   g, 32'(bsy[g]), 32'(e_bsy[g]));
            chk("done",   g, 32'(dn[g]),  32'(e_dn[g]));
        end
    endtask

    function automatic logic all_ready(input int mask);
        for (int g = 0; g < NDUT; g++) if (mask[g] && !rdy[g]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_ready(input int mask, input int bound);
        int n;
        n = 0;
        while (!all_ready(mask) && n < bound) begin
            tick();
            n++;
        end
        chk("ready_wait", mask, 32'(all_ready(mask)), 32'd1);
    endtask

    task automatic wait_k(input int ta, input int k);
        while (cyc - ta < k) tick();
    endtask

    // Offer one byte for a single cycle; ta is the cycle count after the accept edge.
    task automatic send_pulse(input int mask, input logic [1:0] b, input logic [7:0] d, output int ta);
        wait_ready(mask, 20000);
        baud_rate = b;
        tx_data   = d;
        tx_valid  = 1'b1;
        tick();
        ta = cyc;
        tx_valid = 1'b0;
    endtask

    initial begin
        vec_t        tbl [6];
        int          ta, p, n, guard;
        int          dt [3];
        logic [9:0]  t1_bits;

        tbl[0] = '{2'b11, 8'h55, 10'b1010101010, 540};
        tbl[1] = '{2'b10, 8'hA3, 10'b1101000110, 810};
        tbl[2] = '{2'b01, 8'h07, 10'b1000001110, 1620};
        tbl[3] = '{2'b11, 8'hFF, 10'b1111111110, 540};
        tbl[4] = '{2'b11, 8'h00, 10'b1000000000, 540};
        tbl[5] = '{2'b10, 8'h80, 10'b1100000000, 810};
        t1_bits = 10'b1010101010;
        dt = '{0, 0, 0};

        // Reset state
        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) begin
            chk("rst_serial", g, 32'(ser[g]), 32'd1);
            chk("rst_ready",  g, 32'(rdy[g]), 32'd1);
            chk("rst_busy",   g, 32'(bsy[g]), 32'd0);
            chk("rst_done",   g, 32'(dn[g]),  32'd0);
        end
        reset_n = 1'b1;
        repeat (3) tick();

        // Table-driven single frames on DUT 3
        for (int i = 0; i < 6; i++) begin
            send_pulse(1 << 3, tbl[i].baud, tbl[i].data, ta);
            p = tbl[i].cycles / 10;
            for (int b = 0; b < 10; b++) begin
                wait_k(ta, b * p + p / 2);
                chk("tbl_bit", i * 10 + b, 32'(ser[3]), 32'(tbl[i].bits[b]));
            end
            wait_k(ta, tbl[i].cycles - 1);
            chk("tbl_done_early", i, 32'(dn[3]), 32'd0);
            wait_k(ta, tbl[i].cycles);
            chk("tbl_done", i, 32'(dn[3]), 32'd1);
        end

        // Valid held through three frames at 9600 code
        wait_ready(1 << 3, 20000);
        baud_rate = 2'b00;
        tx_data   = 8'hA3;
        tx_valid  = 1'b1;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 12000) begin
            tick();
            guard++;
            if (dn[3]) begin
                dt[n] = cyc;
                n++;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_done_count", 3, n, 3);
        chk("b2b_gap", 0, dt[1] - dt[0], 3251);
        chk("b2b_gap", 1, dt[2] - dt[1], 3251);

        // Baud code changed mid-frame
        send_pulse(1 << 3, 2'b00, 8'h3C, ta);
        wait_k(ta, 1000);
        baud_rate = 2'b11;
        wait_k(ta, 3249);
        chk("baudsw_slow_early", 0, 32'(dn[3]), 32'd0);
        wait_k(ta, 3250);
        chk("baudsw_slow_done", 0, 32'(dn[3]), 32'd1);
        send_pulse(1 << 3, 2'b11, 8'h3C, ta);
        wait_k(ta, 539);
        chk("baudsw_fast_early", 1, 32'(dn[3]), 32'd0);
        wait_k(ta, 540);
        chk("baudsw_fast_done", 1, 32'(dn[3]), 32'd1);

        // Parity odd (DUT 1) and even (DUT 2) on 8'h07
        send_pulse((1 << 1) | (1 << 2), 2'b11, 8'h07, ta);
        wait_k(ta, 9 * 54 + 27);
        chk("parity_odd", 1, 32'(ser[1]), 32'd0);
        chk("parity_even", 2, 32'(ser[2]), 32'd1);
        wait_k(ta, 593);
        chk("even_done_early", 2, 32'(dn[2]), 32'd0);
        wait_k(ta, 594);
        chk("even_done", 2, 32'(dn[2]), 32'd1);
        wait_k(ta, 647);
        chk("odd_done_early", 1, 32'(dn[1]), 32'd0);
        wait_k(ta, 648);
        chk("odd_done", 1, 32'(dn[1]), 32'd1);

        // Two stop bits, valid held while busy (DUT 1, data C7 -> odd parity 0)
        wait_ready(1 << 1, 20000);
        baud_rate = 2'b11;
        tx_data   = 8'hC7;
        tx_valid  = 1'b1;
        tick();
        ta = cyc;
        wait_k(ta, 539);
        chk("stop2_parity", 1, 32'(ser[1]), 32'd0);
        wait_k(ta, 540);
        chk("stop2_stop_start", 1, 32'(ser[1]), 32'd1);
        wait_k(ta, 647);
        chk("stop2_ready_busy", 1, 32'(rdy[1]), 32'd0);
        chk("stop2_stop_end", 1, 32'(ser[1]), 32'd1);
        wait_k(ta, 648);
        chk("stop2_done", 1, 32'(dn[1]), 32'd1);
        wait_k(ta, 649);
        chk("stop2_reaccept", 1, 32'(bsy[1]), 32'd1);
        chk("stop2_restart", 1, 32'(ser[1]), 32'd0);
        wait_k(ta, 649 + 648);
        chk("stop2_done2", 1, 32'(dn[1]), 32'd1);
        tx_valid = 1'b0;

        // Randomised traffic, every DUT checked each cycle against its model
        for (int i = 0; i < 6000; i++) begin
            tx_valid  = ($urandom_range(0, 3) == 0);
            tx_data   = 8'($urandom);
            baud_rate = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            tick();
        end
        tx_valid = 1'b0;

        // Reset during data bit 4 of DUT 3
        send_pulse(1 << 3, 2'b11, 8'h5A, ta);
        wait_k(ta, 5 * 54 + 27);
        chk("midrst_busy_before", 3, 32'(bsy[3]), 32'd1);
        @(posedge system_clk);
        #2;
        reset_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            chk("midrst_serial", g, 32'(ser[g]), 32'd1);
            chk("midrst_ready",  g, 32'(rdy[g]), 32'd1);
            chk("midrst_busy",   g, 32'(bsy[g]), 32'd0);
            chk("midrst_done",   g, 32'(dn[g]),  32'd0);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();

        // Nominal 57600 frame on DUT 0: each bit exactly 3472 cycles
        send_pulse(1 << 0, 2'b11, 8'h55, ta);
        for (int b = 0; b < 10; b++) begin
            wait_k(ta, b * 3472);
            chk("nom_bit_first", b, 32'(ser[0]), 32'(t1_bits[b]));
            wait_k(ta, b * 3472 + 3471);
            chk("nom_bit_last", b, 32'(ser[0]), 32'(t1_bits[b]));
        end
        wait_k(ta, 34719);
        chk("nom_done_early", 0, 32'(dn[0]), 32'd0);
        wait_k(ta, 34720);
        chk("nom_done", 0, 32'(dn[0]), 32'd1);
        tick();
        chk("nom_done_pulse", 0, 32'(dn[0]), 32'd0);
        chk("nom_ready", 0, 32'(rdy[0]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
